var_delay_line: RTL and testbench



---
 rtl/var_delay_line.sv | 107 ++++++++++
 tb/tb_var_delay_line.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/var_delay_line.sv
// Sample-strobed delay line with a runtime delay of 0..MAX_DELAY samples and zero-gating of unwritten history.
// Optional macro VAR_DELAY_FEEDBACK_EN adds an fb_gain port that feeds the output back into the written sample.
module var_delay_line #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_DELAY  = 1024,
  parameter int DW         = $clog2(MAX_DELAY + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [DW-1:0]                delay,
  input  logic signed [DATA_WIDTH-1:0] data_i,
`ifdef VAR_DELAY_FEEDBACK_EN
  input  logic [7:0]                   fb_gain,
`endif
  output logic signed [DATA_WIDTH-1:0] data_o,
  output logic                         valid_o,
  output logic                         primed_o
);

  // Handshake: en is a one-cycle strobe with no back-pressure; valid_o pulses
  // exactly one clk after each accepted strobe, and data_o/primed_o hold until the next one.

  localparam int AA = $clog2(MAX_DELAY);
  localparam int XW = DW + 1;

  logic signed [DATA_WIDTH-1:0] mem [MAX_DELAY];

  logic [AA-1:0]                wr_ptr;
  logic [DW-1:0]                fill_cnt;
  logic [DW-1:0]                eff_d;
  logic [XW-1:0]                wr_x;
  logic [XW-1:0]                d_x;
  logic [XW-1:0]                rd_x;
  logic [AA-1:0]                rd_addr;
  logic                         gate;
  logic signed [DATA_WIDTH-1:0] wr_data;
  logic signed [DATA_WIDTH-1:0] ram_q;
  logic signed [DATA_WIDTH-1:0] byp_q;
  logic                         gate_q;
  logic                         bypass_q;

  // Address math is one bit wider than the delay so wr_ptr - D never underflows.
  always_comb begin
    eff_d   = (delay > DW'(MAX_DELAY)) ? DW'(MAX_DELAY) : delay;
    wr_x    = XW'(wr_ptr);
    d_x     = XW'(eff_d);
    rd_x    = (wr_x >= d_x) ? (wr_x - d_x) : (wr_x + XW'(MAX_DELAY) - d_x);
    rd_addr = AA'(rd_x);
    gate    = (fill_cnt < eff_d);
  end

`ifdef VAR_DELAY_FEEDBACK_EN
  logic signed [DATA_WIDTH+8:0] fb_prod;
  logic signed [DATA_WIDTH+1:0] fb_sum;

  // Two guard bits above the sample width detect overflow of data_i + scaled tap.
  always_comb begin
    fb_prod = (DATA_WIDTH+9)'(data_o) * (DATA_WIDTH+9)'($signed({1'b0, fb_gain}));
    fb_sum  = (DATA_WIDTH+2)'(data_i) + (DATA_WIDTH+2)'(fb_prod >>> 8);
    if ((fb_sum[DATA_WIDTH+1:DATA_WIDTH-1] == 3'b000) ||
        (fb_sum[DATA_WIDTH+1:DATA_WIDTH-1] == 3'b111))
      wr_data = fb_sum[DATA_WIDTH-1:0];
    else if (fb_sum[DATA_WIDTH+1])
      wr_data = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    else
      wr_data = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  end
`else
  assign wr_data = data_i;
`endif

  // Read-first single-port-style RAM: at D=MAX_DELAY rd_addr == wr_ptr and the old word is returned.
  always_ff @(posedge clk) begin
    if (en && !rst) begin
      mem[wr_ptr] <= wr_data;
      ram_q       <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      fill_cnt <= '0;
      valid_o  <= 1'b0;
      primed_o <= 1'b0;
      gate_q   <= 1'b1;
      bypass_q <= 1'b0;
      byp_q    <= '0;
    end else begin
      valid_o <= en;
      if (en) begin
        wr_ptr <= (wr_ptr == AA'(MAX_DELAY - 1)) ? '0 : wr_ptr + AA'(1);
        if (fill_cnt != DW'(MAX_DELAY))
          fill_cnt <= fill_cnt + DW'(1);
        primed_o <= !gate;
        gate_q   <= gate;
        bypass_q <= (eff_d == '0);
        byp_q    <= wr_data;
      end
    end
  end

  // Gated strobes output zero; bypass strobes return the sample written on that same strobe.
  assign data_o = gate_q ? '0 : (bypass_q ? byp_q : ram_q);

endmodule

// File: tb/tb_var_delay_line.sv
// Randomised bench for var_delay_line: two instances (MAX_DELAY 1024 and 8) against a history-queue model.
// Define VAR_DELAY_FEEDBACK_EN to exercise the fb_gain path as well.
module tb_var_delay_line;

  localparam int BIG   = 1024;
  localparam int SMALL = 8;
  localparam int BDW   = $clog2(BIG + 1);
  localparam int SDW   = $clog2(SMALL + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic signed [15:0] data_i;
  logic [BDW-1:0]    big_delay;
  logic [SDW-1:0]    small_delay;
  logic signed [15:0] big_data;
  logic signed [15:0] small_data;
  logic              big_valid;
  logic              small_valid;
  logic              big_primed;
  logic              small_primed;
`ifdef VAR_DELAY_FEEDBACK_EN
  logic [7:0]        fb_gain;
  int                want_fb;
`endif

  int want_bd;
  int want_sd;

  always #5 clk = ~clk;

  var_delay_line #(.DATA_WIDTH(16), .MAX_DELAY(BIG)) u_big (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .delay    (big_delay),
    .data_i   (data_i),
`ifdef VAR_DELAY_FEEDBACK_EN
    .fb_gain  (fb_gain),
`endif
    .data_o   (big_data),
    .valid_o  (big_valid),
    .primed_o (big_primed)
  );

  var_delay_line #(.DATA_WIDTH(16), .MAX_DELAY(SMALL)) u_small (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .delay    (small_delay),
    .data_i   (data_i),
`ifdef VAR_DELAY_FEEDBACK_EN
    .fb_gain  (fb_gain),
`endif
    .data_o   (small_data),
    .valid_o  (small_valid),
    .primed_o (small_primed)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // History of written samples per instance; output is the sample D strobes back,
  // zero while fewer than D samples have been written since reset.
  int hq0[$];
  int hq1[$];
  int m_out[2];
  int m_cnt[2];
  int m_primed[2];
  int exp_valid;

  function automatic void model_reset();
    hq0.delete();
    hq1.delete();
    for (int i = 0; i < 2; i++) begin
      m_out[i]    = 0;
      m_cnt[i]    = 0;
      m_primed[i] = 0;
    end
    exp_valid = 0;
  endfunction

  function automatic void model_strobe(input int idx, input int req, input int din);
    int maxd;
    int d;
    int w;
    int past;
    maxd = (idx == 0) ? BIG : SMALL;
    d    = (req > maxd) ? maxd : req;
    w    = din;
`ifdef VAR_DELAY_FEEDBACK_EN
    w = din + ((m_out[idx] * want_fb) >>> 8);
    if (w > 32767)  w = 32767;
    if (w < -32768) w = -32768;
`endif
    past = 0;
    if (idx == 0) begin
      if (d > 0 && hq0.size() >= d) past = hq0[hq0.size() - d];
      hq0.push_back(w);
      if (hq0.size() > maxd) void'(hq0.pop_front());
    end else begin
      if (d > 0 && hq1.size() >= d) past = hq1[hq1.size() - d];
      hq1.push_back(w);
      if (hq1.size() > maxd) void'(hq1.pop_front());
    end
    m_primed[idx] = (m_cnt[idx] >= d) ? 1 : 0;
    if (m_cnt[idx] < d)  m_out[idx] = 0;
    else if (d == 0)     m_out[idx] = w;
    else                 m_out[idx] = past;
    m_cnt[idx]++;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic check_outputs();
    check("big_valid",    int'(big_valid),    exp_valid);
    check("big_data",     int'(big_data),     m_out[0]);
    check("big_primed",   int'(big_primed),   m_primed[0]);
    check("small_valid",  int'(small_valid),  exp_valid);
    check("small_data",   int'(small_data),   m_out[1]);
    check("small_primed", int'(small_primed), m_primed[1]);
  endtask

  // Checks the previous cycle's outputs, then drives this cycle's inputs at the falling edge.
  task automatic step(input bit e, input int din);
    @(negedge clk);
    check_outputs();
    big_delay   = BDW'(want_bd);
    small_delay = SDW'(want_sd);
`ifdef VAR_DELAY_FEEDBACK_EN
    fb_gain = 8'(want_fb);
`endif
    en     = e;
    data_i = 16'(din);
    if (e) begin
      model_strobe(0, want_bd, din);
      model_strobe(1, want_sd, din);
    end
    exp_valid = e ? 1 : 0;
  endtask

  // en is left at its last value across the reset edge, so a pending strobe must be dropped.
  task automatic do_reset();
    @(negedge clk);
    check_outputs();
    rst = 1'b1;
    @(negedge clk);
    check("rst_big_valid",   int'(big_valid),   0);
    check("rst_big_data",    int'(big_data),    0);
    check("rst_big_primed",  int'(big_primed),  0);
    check("rst_small_valid", int'(small_valid), 0);
    check("rst_small_data",  int'(small_data),  0);
    rst = 1'b0;
    en  = 1'b0;
    model_reset();
  endtask

  function automatic int rand_sample();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst         = 1'b1;
    en          = 1'b0;
    data_i      = '0;
    big_delay   = '0;
    small_delay = '0;
    want_bd     = 0;
    want_sd     = 0;
`ifdef VAR_DELAY_FEEDBACK_EN
    fb_gain = '0;
    want_fb = 0;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    step(0, 0);

    // Ramp through delay 4, then idle cycles to confirm the outputs hold.
    want_bd = 4;
    want_sd = 4;
    for (int i = 1; i <= 12; i++) step(1, i);
    step(0, 0);
    step(0, 0);

    // Bypass with random data, back-to-back and with gaps.
    want_bd = 0;
    want_sd = 0;
    for (int i = 0; i < 20; i++) step(1, rand_sample());
    for (int i = 0; i < 10; i++) step($urandom_range(0, 1) == 1, rand_sample());

    // Full-depth delay on the small instance across the pointer wrap.
    do_reset();
    want_bd = 8;
    want_sd = 8;
    for (int i = 1; i <= 20; i++) step(1, i);

    // Large delay while gated, then drop to 5.
    do_reset();
    want_bd = 1000;
    want_sd = 15;
    for (int i = 1; i <= 10; i++) step(1, i * 7);
    want_bd = 5;
    want_sd = 5;
    for (int i = 11; i <= 20; i++) step(1, i * 7);

    // Mid-stream reset with a strobe in flight; stale memory must stay hidden.
    want_bd = 3;
    want_sd = 3;
    for (int i = 0; i < 50; i++) step(1, rand_sample());
    do_reset();
    for (int i = 1; i <= 10; i++) step(1, 100 + i);

`ifdef VAR_DELAY_FEEDBACK_EN
    // Echo decay with half gain, then positive and negative saturation in bypass.
    do_reset();
    want_bd = 2;
    want_sd = 2;
    want_fb = 128;
    step(1, 16384);
    for (int i = 0; i < 12; i++) step(1, 0);
    want_bd = 0;
    want_sd = 0;
    want_fb = 255;
    for (int i = 0; i < 5; i++) step(1, 32767);
    for (int i = 0; i < 5; i++) step(1, -32768);
    want_fb = 0;
`endif

    // Long randomised run: gaps, delay changes (including clamped values), rare resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        want_bd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2047)) : int'($urandom_range(0, 40));
        want_sd = int'($urandom_range(0, 15));
      end
`ifdef VAR_DELAY_FEEDBACK_EN
      if ($urandom_range(0, 99) == 0)
        want_fb = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 255));
`endif
      if ($urandom_range(0, 599) == 0) do_reset();
      step($urandom_range(0, 3) != 0, rand_sample());
    end

    @(negedge clk);
    check_outputs();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
